// File: rtl/risc16_ctrl_fsm.sv
// rtl/risc16_ctrl_fsm.sv - multi-cycle RiSC-16 control sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT)
// Optional retire counter: define RISC16_RETIRE_CNT_EN.
`ifndef WORD_LEN
`define WORD_LEN 16
`endif
`ifndef FUNCT_LEN
`define FUNCT_LEN 1
`endif

module risc16_ctrl_fsm #(
  parameter logic [`WORD_LEN-1:0] HALT_WORD = 16'hE071,
  parameter int                   CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [`WORD_LEN-1:0]  instr,
  input  logic                  mem_ack,
  input  logic                  alu_stat,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  addr_sel,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic                  rd2_sel,
  output logic                  srcb_sel,
  output logic [`FUNCT_LEN-1:0] alu_funct,
  output logic                  rf_we,
  output logic [1:0]            wb_sel,
  output logic                  halted
`ifdef RISC16_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]      retired
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_t     state;
  logic [2:0] op;        // only the opcode field of IR steers the sequencer
  logic       halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      op       <= 3'b000;
      halted_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            op <= instr[15:13];
            if (instr == HALT_WORD) begin
              state    <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state <= S_DECODE;
            end
          end
        end
        S_DECODE: state <= (op == OP_LUI) ? S_WB : S_EXEC;
        S_EXEC: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEM;
            OP_BEQ:       state <= S_FETCH;
            default:      state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ack) state <= (op == OP_LW) ? S_WB : S_FETCH;
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    rd2_sel   = 1'b0;
    srcb_sel  = 1'b0;
    alu_funct = '0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    halted    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ack;
        end
        S_DECODE: rd2_sel = (op == OP_SW) || (op == OP_BEQ);
        S_EXEC: begin
          rd2_sel   = (op == OP_SW) || (op == OP_BEQ);
          srcb_sel  = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
          alu_funct = (op == OP_NAND) ? `FUNCT_LEN'(1) : `FUNCT_LEN'(0);
          if (op == OP_BEQ) begin
            pc_we  = 1'b1;
            pc_sel = alu_stat ? 2'd1 : 2'd0;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          srcb_sel = 1'b1;
          mem_we   = (op == OP_SW);
          pc_we    = (op == OP_SW) && mem_ack;
        end
        S_WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
          // Link value and jump target both come from the pre-update PC.
          case (op)
            OP_LW:   wb_sel = 2'd1;
            OP_LUI:  wb_sel = 2'd2;
            OP_JALR: wb_sel = 2'd3;
            default: wb_sel = 2'd0;
          endcase
          pc_sel = (op == OP_JALR) ? 2'd2 : 2'd0;
        end
        S_HALT:  halted = halted_q;
        default: ;
      endcase
    end
  end

`ifdef RISC16_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)        retired <= '0;
    else if (pc_we) retired <= retired + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// tb/tb_risc16_ctrl_fsm.sv - vector-table and scoreboard bench for risc16_ctrl_fsm
// Checks retired count as well when RISC16_RETIRE_CNT_EN is defined.
`ifndef WORD_LEN
`define WORD_LEN 16
`endif
`ifndef FUNCT_LEN
`define FUNCT_LEN 1
`endif

module tb_risc16_ctrl_fsm;
  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [`WORD_LEN-1:0]  instr = '0;
  logic                  mem_ack = 1'b0;
  logic                  alu_stat = 1'b0;
  logic                  mem_req, mem_we, addr_sel, ir_we, pc_we, rd2_sel, srcb_sel, rf_we, halted;
  logic [1:0]            pc_sel, wb_sel;
  logic [`FUNCT_LEN-1:0] alu_funct;
`ifdef RISC16_RETIRE_CNT_EN
  logic [31:0]           retired;
`endif

  risc16_ctrl_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ack(mem_ack), .alu_stat(alu_stat),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rd2_sel(rd2_sel), .srcb_sel(srcb_sel),
    .alu_funct(alu_funct), .rf_we(rf_we), .wb_sel(wb_sel), .halted(halted)
`ifdef RISC16_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] word;
    bit          stat;
    int          fwait, mwait;
    int          cycles, psel, wb, rf, mwe, fn, srcb, rd2, req;
  } vec_t;

  vec_t vecs[10];
  vec_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   wcnt = 0;

  function automatic vec_t mk(string n, logic [15:0] w, bit s, int fw, int mw, int cy,
                              int ps, int wb, int rf, int mwe, int fn, int sb, int r2, int rq);
    vec_t v;
    v.name = n; v.word = w; v.stat = s; v.fwait = fw; v.mwait = mw; v.cycles = cy;
    v.psel = ps; v.wb = wb; v.rf = rf; v.mwe = mwe; v.fn = fn; v.srcb = sb; v.rd2 = r2; v.req = rq;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [14:0] all_out();
    return {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rd2_sel, srcb_sel,
            alu_funct[0], rf_we, wb_sel, halted, 1'b0};
  endfunction

  // One clock: memory model answers a visible request after fw/mw wait cycles.
  task automatic step(input int fw, input int mw);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    if (mem_req) begin
      if (wcnt >= (addr_sel ? mw : fw)) begin
        mem_ack = 1'b1;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
    #1;
  endtask

  task automatic run_instr(input vec_t v);
    int cyc = 0, rf_cnt = 0, ir_cnt = 0, req_cnt = 0, psel = -1, wbs = -1;
    int mwe = 0, fn = 0, sb = 0, r2 = 0;
    bit done = 0;
    vec_t e;
    sb_q.push_back(v);
    instr = v.word;
    alu_stat = v.stat;
    wcnt = 0;
    while (!done && cyc < 40) begin
      step(v.fwait, v.mwait);
      cyc++;
      if (mem_req) req_cnt++;
      if (ir_we) ir_cnt++;
      if (rf_we) begin rf_cnt++; wbs = int'(wb_sel); end
      if (mem_we) mwe = 1;
      if (alu_funct != 0) fn = 1;
      if (srcb_sel) sb = 1;
      if (rd2_sel) r2 = 1;
      if (pc_we) begin psel = int'(pc_sel); done = 1; end
    end
    e = sb_q.pop_front();
    chk({e.name, " completes"}, int'(done), 1);
    chk({e.name, " cycles"}, cyc, e.cycles);
    chk({e.name, " pc_sel"}, psel, e.psel);
    chk({e.name, " rf_we count"}, rf_cnt, e.rf);
    chk({e.name, " wb_sel"}, wbs, e.wb);
    chk({e.name, " mem_we"}, mwe, e.mwe);
    chk({e.name, " alu_funct"}, fn, e.fn);
    chk({e.name, " srcb_sel"}, sb, e.srcb);
    chk({e.name, " rd2_sel"}, r2, e.rd2);
    chk({e.name, " mem_req cycles"}, req_cnt, e.req);
    chk({e.name, " ir_we count"}, ir_cnt, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1000, 1000);
    chk("outputs zero in reset", int'(all_out()), 0);
    rst = 1'b0;
  endtask

  initial begin
    int   found;
    int   seen;
    logic [14:0] acc;

    //             name      word     st fw mw cyc ps  wb rf mwe fn sb r2 req
    vecs[0] = mk("ADD",     16'h0482, 0, 0, 0, 4,  0,  0, 1, 0,  0, 0, 0, 1);
    vecs[1] = mk("NAND",    16'h4482, 0, 0, 0, 4,  0,  0, 1, 0,  1, 0, 0, 1);
    vecs[2] = mk("ADDI",    16'h2485, 0, 0, 0, 4,  0,  0, 1, 0,  0, 1, 0, 1);
    vecs[3] = mk("LUI",     16'h6481, 0, 0, 0, 3,  0,  2, 1, 0,  0, 0, 0, 1);
    vecs[4] = mk("BEQ_T",   16'hC481, 1, 0, 0, 3,  1, -1, 0, 0,  0, 0, 1, 1);
    vecs[5] = mk("BEQ_NT",  16'hC481, 0, 0, 0, 3,  0, -1, 0, 0,  0, 0, 1, 1);
    vecs[6] = mk("LW_W2",   16'hA481, 0, 0, 2, 7,  0,  1, 1, 0,  0, 1, 0, 4);
    vecs[7] = mk("SW",      16'h8481, 0, 0, 0, 4,  0, -1, 0, 1,  0, 1, 1, 2);
    vecs[8] = mk("JALR",    16'hE480, 0, 0, 0, 4,  2,  3, 1, 0,  0, 0, 0, 1);
    vecs[9] = mk("ADD_FW3", 16'h0482, 0, 3, 0, 7,  0,  0, 1, 0,  0, 0, 0, 4);

    rst = 1'b1;
    step(1000, 1000);
    do_reset();
    step(1000, 1000);
    chk("post-reset mem_req", int'(mem_req), 1);
    chk("post-reset addr_sel", int'(addr_sel), 0);
    chk("post-reset halted", int'(halted), 0);

    for (int i = 0; i < 10; i++) run_instr(vecs[i]);

    // Reset while LW is stalled in MEM.
    instr = 16'hA481; alu_stat = 1'b0; wcnt = 0; found = 0; seen = 0;
    for (int i = 0; i < 20 && found < 3; i++) begin
      step(0, 1000);
      if (pc_we || rf_we) seen = 1;
      if (mem_req && addr_sel) found++;
    end
    chk("mid-LW reached MEM", found, 3);
    do_reset();
    step(1000, 1000);
    chk("mid-LW back in FETCH", int'(mem_req && !addr_sel), 1);
    chk("mid-LW no pc_we/rf_we", seen | int'(pc_we) | int'(rf_we), 0);

    // Halt word: IR loaded, then absorbing.
    instr = 16'hE071; wcnt = 0;
    step(0, 0);
    chk("halt fetch ir_we", int'(ir_we), 1);
    chk("halt fetch pc_we", int'(pc_we), 0);
    chk("halt fetch halted", int'(halted), 0);
    step(0, 0);
    chk("halted next cycle", int'(halted), 1);
    acc = '0; found = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0);
      acc |= {mem_req, ir_we, pc_we, rf_we, 11'd0};
      if (halted) found++;
    end
    chk("halt strobes quiet", int'(acc), 0);
    chk("halt sticky cycles", found, 20);
    do_reset();
    step(1000, 1000);
    chk("after halt reset FETCH", int'(mem_req), 1);
    chk("after halt reset halted", int'(halted), 0);

    do_reset();
`ifdef RISC16_RETIRE_CNT_EN
    chk("retired after reset", int'(retired), 0);
`endif
    run_instr(vecs[0]);
    run_instr(vecs[3]);
    run_instr(vecs[4]);
`ifdef RISC16_RETIRE_CNT_EN
    @(negedge clk);
    chk("retired after 3 instrs", int'(retired), 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/risc16_ctrl_fsm.md
Name: risc16_ctrl_fsm

Overview:
Multi-cycle control sequencer for the non-pipelined RiSC-16 core. It sits directly upstream of the ALU and drives `alu_funct`, the ALU operand select and every datapath strobe. It consumes the ALU `stat` flag for BEQ. It fetches through a req/ack memory handshake, decodes the 3-bit opcode and steps FETCH/DECODE/EXEC/MEM/WB until a halt word is seen.

Parameters:
HALT_WORD, 16'hE071, instruction word that stops the sequencer (`jalr r0,r0` with imm 113)
CNT_W, 32, width of the retire counter (used only with the optional feature)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous, active-high reset
instr  in  `WORD_LEN  memory read data, valid when mem_ack=1 in FETCH
mem_ack  in  1  memory completes the current request this cycle
alu_stat  in  1  ALU equality flag (ina==inb), valid for any funct
mem_req  out  1  memory request, held until ack
mem_we  out  1  write qualifier for mem_req (SW only)
addr_sel  out  1  memory address: 0=PC, 1=ALU out
ir_we  out  1  load IR from instr
pc_we  out  1  update PC
pc_sel  out  2  0=PC+1, 1=PC+1+sext(imm7), 2=rB
rd2_sel  out  1  second read port index: 0=rC, 1=rA
srcb_sel  out  1  ALU B operand: 0=reg port 2, 1=sext(imm7)
alu_funct  out  `FUNCT_LEN  0=ADD, 1=NAND
rf_we  out  1  register write strobe
wb_sel  out  2  0=ALU, 1=mem data, 2=imm10<<6, 3=PC+1
halted  out  1  sticky halt indicator

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Opcode is IR[15:13]: ADD 000, ADDI 001, NAND 010, LUI 011, SW 100, LW 101, BEQ 110, JALR 111.
- Outputs are decoded from state and IR. Strobes (mem_req, ir_we, pc_we, rf_we) assert only in the cycles listed below; otherwise 0.
- Reset: rst sampled high sets state to FETCH and clears IR and halted. While rst=1 all outputs are forced to 0. The first cycle after release is FETCH.
- Reset mid-operation: an outstanding memory request is abandoned (mem_req drops), with no pc_we and no rf_we.
- FETCH: mem_req=1, addr_sel=0. On mem_ack, assert ir_we and go to DECODE; if instr==HALT_WORD go to HALT instead (IR still loaded, no pc_we). With no ack, stay in FETCH indefinitely.
- DECODE (1 cycle): rd2_sel=1 for SW/BEQ. Next state is WB for LUI, EXEC otherwise.
- EXEC (1 cycle): alu_funct=1 for NAND, 0 otherwise. srcb_sel=1 for ADDI/LW/SW; rd2_sel as in DECODE.
  - ADD/ADDI/NAND/JALR go to WB.
  - LW/SW go to MEM.
  - BEQ: pc_we=1, pc_sel = alu_stat ? 1 : 0, then FETCH.
- MEM: mem_req=1, addr_sel=1, srcb_sel=1, mem_we=1 for SW, holding until mem_ack.
  - LW on ack: go to WB.
  - SW on ack: pc_we=1, pc_sel=0, go to FETCH.
- WB (1 cycle): rf_we=1, pc_we=1, then FETCH.
  - wb_sel: ALU for ADD/ADDI/NAND, mem for LW, imm for LUI, PC+1 for JALR.
  - pc_sel=2 for JALR, 0 otherwise. Link write and PC update share this edge, both using the old PC.
  - Writes to r0 are still strobed; the register file discards them.
- HALT: absorbing until rst. halted=1; every strobe is 0.
- Latencies with zero-wait memory (ack in the same cycle as req):
  - ADD/ADDI/NAND/JALR: 4 cycles
  - LUI: 3 cycles
  - BEQ: 3 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - Each memory wait cycle adds 1.
- mem_req never deasserts before ack except on reset. mem_ack while mem_req=0 is ignored.

Optional Feature:
RISC16_RETIRE_CNT_EN:
- Defined: adds output `retired`, width CNT_W.
  - Cleared by rst.
  - Increments by 1 on every cycle that asserts pc_we (i.e. each completed instruction).
  - Wraps modulo 2^CNT_W.
  - Holds in HALT.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

Test Plan:
- Reset, then ADD word 16'h0482 with immediate ack → FETCH,DECODE,EXEC,WB. In WB: rf_we=1, wb_sel=0, pc_we=1, pc_sel=0; alu_funct=0 in EXEC.
- NAND 16'h4482 → alu_funct=1 in EXEC; ADDI 16'h2485 → srcb_sel=1 in EXEC; both take 4 cycles.
- BEQ 16'hC481 with alu_stat=1 → pc_we with pc_sel=1 in cycle 3. Repeat with alu_stat=0 → pc_sel=0, and rf_we never asserts.
- LW 16'hA481 with 2-cycle ack delay in MEM → mem_req/addr_sel=1 held 3 cycles, mem_we=0, then WB with wb_sel=1; 7 cycles total. SW 16'h8481 → mem_we=1, pc_we on ack, no rf_we.
- Fetch 16'hE071 → halted=1 next cycle; strobes stay 0 for 20 cycles; rst → FETCH, halted=0.
- Assert rst mid-LW while MEM is waiting → next cycle FETCH, no rf_we/pc_we. With RISC16_RETIRE_CNT_EN, retired reads 0 after reset and 3 after ADD, LUI, BEQ.
